// File: rtl/dcf77_sync_ctrl_pkg.sv
// Shared types, DCF77 frame bit positions and BCD helpers for the sync controller.
package dcf77_sync_ctrl_pkg;

    typedef logic [7:0] bcd_t;

    typedef enum logic [1:0] {
        ST_HUNT     = 2'd0,
        ST_VERIFY   = 2'd1,
        ST_LOCKED   = 2'd2,
        ST_HOLDOVER = 2'd3
    } dcf77_state_t;

    typedef struct packed {
        bcd_t minute;
        bcd_t hour;
        bcd_t day;
        bcd_t dow;
        bcd_t month;
        bcd_t year;
    } dcf77_time_t;

    localparam int BIT_START      = 0;
    localparam int BIT_TIME_START = 20;
    localparam int MIN_LSB        = 21;
    localparam int MIN_PAR        = 28;
    localparam int HOUR_LSB       = 29;
    localparam int HOUR_PAR       = 35;
    localparam int DAY_LSB        = 36;
    localparam int DOW_LSB        = 42;
    localparam int MON_LSB        = 45;
    localparam int YEAR_LSB       = 50;
    localparam int DATE_PAR       = 58;

    // Both digits must be decimal; then plain numeric compare orders BCD correctly.
    function automatic logic bcd_in_range(input bcd_t v, input bcd_t lo, input bcd_t hi);
        return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v >= lo) && (v <= hi);
    endfunction

    function automatic bcd_t bcd_minute_inc(input bcd_t m);
        if (m == 8'h59) begin
            return 8'h00;
        end
        if (m[3:0] == 4'd9) begin
            return {m[7:4] + 4'd1, 4'd0};
        end
        return {m[7:4], m[3:0] + 4'd1};
    endfunction

endpackage

// File: rtl/dcf77_frame_check.sv
// Combinational validity check of one DCF77 minute frame and BCD field extraction.
module dcf77_frame_check
    import dcf77_sync_ctrl_pkg::*;
(
    input  logic        frame_error_i,
    input  logic [58:0] data_i,
    output logic        valid_o,
    output dcf77_time_t fields_o
);

    logic par_ok;
    logic range_ok;
    logic unused_bits;

    // Bits 1..19 carry weather and announcement flags that timekeeping ignores.
    assign unused_bits = ^data_i[BIT_TIME_START-1:BIT_START+1];

    always_comb begin
        fields_o.minute = {1'b0, data_i[MIN_LSB +: 7]};
        fields_o.hour   = {2'b0, data_i[HOUR_LSB +: 6]};
        fields_o.day    = {2'b0, data_i[DAY_LSB +: 6]};
        fields_o.dow    = {5'b0, data_i[DOW_LSB +: 3]};
        fields_o.month  = {3'b0, data_i[MON_LSB +: 5]};
        fields_o.year   = data_i[YEAR_LSB +: 8];

        par_ok = (^data_i[MIN_PAR:MIN_LSB] == 1'b0)
              && (^data_i[HOUR_PAR:HOUR_LSB] == 1'b0)
              && (^data_i[DATE_PAR:DAY_LSB] == 1'b0);

        range_ok = bcd_in_range(fields_o.minute, 8'h00, 8'h59)
                && bcd_in_range(fields_o.hour,   8'h00, 8'h23)
                && bcd_in_range(fields_o.day,    8'h01, 8'h31)
                && bcd_in_range(fields_o.dow,    8'h01, 8'h07)
                && bcd_in_range(fields_o.month,  8'h01, 8'h12)
                && bcd_in_range(fields_o.year,   8'h00, 8'h99);

        valid_o = !frame_error_i && !data_i[BIT_START] && data_i[BIT_TIME_START]
               && par_ok && range_ok;
    end

endmodule

// File: rtl/dcf77_sync_ctrl.sv
// DCF77 synchronisation controller: frame consistency tracking, lock FSM and minute timeout.
module dcf77_sync_ctrl
    import dcf77_sync_ctrl_pkg::*;
#(
    parameter int N_CONFIRM     = 2,
    parameter int HOLDOVER_MAX  = 60,
    parameter int TIMEOUT_TICKS = 6100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_en,
    input  logic        frame_valid,
    input  logic        frame_error,
    input  logic [58:0] data,
    output logic        load,
    output logic        locked,
    output logic [1:0]  state,
    output logic [7:0]  missed
);

    localparam int          CNT_W     = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [3:0]  N_CONF    = 4'(N_CONFIRM);
    localparam logic [7:0]  HOLD_MAX  = 8'(HOLDOVER_MAX);
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TIMEOUT_TICKS - 1);

    dcf77_state_t     state_q, state_d;
    logic [3:0]       confirm_q, confirm_d;
    logic [7:0]       missed_q, missed_d;
    logic [CNT_W-1:0] tick_q, tick_d;
    dcf77_time_t      ref_q, ref_d;
    logic             ref_vld_q, ref_vld_d;
    logic             load_q, load_d;
    logic             locked_q, locked_d;

    logic        frame_is_valid;
    dcf77_time_t frame_fields;
    logic        timeout_hit;
    logic        timeout_evt;
    logic        frame_ok;
    logic        consistent;
    logic [7:0]  missed_inc;
    logic [3:0]  confirm_inc;

    dcf77_frame_check u_check (
        .frame_error_i (frame_error),
        .data_i        (data),
        .valid_o       (frame_is_valid),
        .fields_o      (frame_fields)
    );

    // A frame arriving on the terminal tick wins; that timeout is dropped.
    assign timeout_hit = clk_en && (tick_q == TICK_LAST);
    assign timeout_evt = timeout_hit && !frame_valid;
    assign frame_ok    = frame_valid && frame_is_valid;
    assign missed_inc  = (missed_q == 8'hFF) ? 8'hFF : missed_q + 8'd1;
    assign confirm_inc = confirm_q + 4'd1;

    // Across the hour rollover (xx:59 -> 00) the date/hour fields may legitimately change.
    assign consistent = frame_ok && ref_vld_q
                     && (frame_fields.minute == bcd_minute_inc(ref_q.minute))
                     && ((frame_fields.minute == 8'h00)
                         || ((frame_fields.hour  == ref_q.hour)
                          && (frame_fields.day   == ref_q.day)
                          && (frame_fields.dow   == ref_q.dow)
                          && (frame_fields.month == ref_q.month)
                          && (frame_fields.year  == ref_q.year)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_HUNT;
            confirm_q <= 4'd0;
            missed_q  <= 8'd0;
            tick_q    <= '0;
            ref_q     <= '0;
            ref_vld_q <= 1'b0;
            load_q    <= 1'b0;
            locked_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            confirm_q <= confirm_d;
            missed_q  <= missed_d;
            tick_q    <= tick_d;
            ref_q     <= ref_d;
            ref_vld_q <= ref_vld_d;
            load_q    <= load_d;
            locked_q  <= locked_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        confirm_d = confirm_q;
        missed_d  = missed_q;
        case (state_q)
            ST_HUNT: begin
                if (frame_ok) begin
                    confirm_d = 4'd1;
                    if (N_CONF == 4'd1) begin
                        state_d  = ST_LOCKED;
                        missed_d = 8'd0;
                    end else begin
                        state_d = ST_VERIFY;
                    end
                end
            end
            ST_VERIFY: begin
                if (consistent) begin
                    confirm_d = confirm_inc;
                    if (confirm_inc >= N_CONF) begin
                        state_d  = ST_LOCKED;
                        missed_d = 8'd0;
                    end
                end else if (frame_ok) begin
                    confirm_d = 4'd1;
                end else if (frame_valid || timeout_evt) begin
                    state_d   = ST_HUNT;
                    confirm_d = 4'd0;
                end
            end
            ST_LOCKED: begin
                if (!consistent && (frame_valid || timeout_evt)) begin
                    state_d  = ST_HOLDOVER;
                    missed_d = 8'd1;
                end
            end
            ST_HOLDOVER: begin
                if (consistent) begin
                    state_d  = ST_LOCKED;
                    missed_d = 8'd0;
                end else if (frame_valid || timeout_evt) begin
                    missed_d = missed_inc;
                    if (missed_inc > HOLD_MAX) begin
                        state_d   = ST_HUNT;
                        confirm_d = 4'd0;
                    end
                end
            end
            default: state_d = ST_HUNT;
        endcase
    end

    always_comb begin
        load_d   = consistent && (state_d == ST_LOCKED);
        locked_d = (state_d == ST_LOCKED) || (state_d == ST_HOLDOVER);
    end

    always_comb begin
        tick_d    = tick_q;
        ref_d     = ref_q;
        ref_vld_d = ref_vld_q;
        if (frame_valid || timeout_hit) begin
            tick_d = '0;
        end else if (clk_en) begin
            tick_d = tick_q + 1'b1;
        end
        if (frame_valid) begin
            ref_vld_d = frame_is_valid;
            if (frame_is_valid) begin
                ref_d = frame_fields;
            end
        end
    end

    assign load   = load_q;
    assign locked = locked_q;
    assign state  = state_q;
    assign missed = missed_q;

endmodule

// File: tb/tb_dcf77_sync_ctrl.sv
// Directed bench for dcf77_sync_ctrl with hand-built frames and expected outputs.
module tb_dcf77_sync_ctrl;

    localparam int TO = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clk_en = 1'b0;
    logic        frame_valid = 1'b0;
    logic        frame_error = 1'b0;
    logic [58:0] data = '0;
    logic        load;
    logic        locked;
    logic [1:0]  state;
    logic [7:0]  missed;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    dcf77_sync_ctrl #(
        .N_CONFIRM     (2),
        .HOLDOVER_MAX  (60),
        .TIMEOUT_TICKS (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clk_en      (clk_en),
        .frame_valid (frame_valid),
        .frame_error (frame_error),
        .data        (data),
        .load        (load),
        .locked      (locked),
        .state       (state),
        .missed      (missed)
    );

    function automatic logic [58:0] mk(input logic [7:0] mi, input logic [7:0] hr,
                                       input logic [7:0] dy, input logic [7:0] dw,
                                       input logic [7:0] mo, input logic [7:0] yr);
        logic [58:0] f;
        f        = '0;
        f[20]    = 1'b1;
        f[27:21] = mi[6:0];
        f[28]    = ^mi[6:0];
        f[34:29] = hr[5:0];
        f[35]    = ^hr[5:0];
        f[41:36] = dy[5:0];
        f[44:42] = dw[2:0];
        f[49:45] = mo[4:0];
        f[57:50] = yr;
        f[58]    = ^f[57:36];
        return f;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input int st, input int ld,
                              input int lk, input int ms);
        check({tag, "/state"},  32'(state),  32'(st));
        check({tag, "/load"},   32'(load),   32'(ld));
        check({tag, "/locked"}, 32'(locked), 32'(lk));
        check({tag, "/missed"}, 32'(missed), 32'(ms));
    endtask

    task automatic send(input string tag, input logic [58:0] f, input logic err);
        @(negedge clk);
        data        = f;
        frame_error = err;
        frame_valid = 1'b1;
        @(negedge clk);
        frame_valid = 1'b0;
        frame_error = 1'b0;
        $display("frame %s: state=%0d load=%0d locked=%0d missed=%0d",
                 tag, state, load, locked, missed);
    endtask

    logic [58:0] f_bad;

    initial begin
        repeat (2) @(negedge clk);
        expect_out("reset", 0, 0, 0, 0);
        rst = 1'b1;

        send("err_flag", mk(8'h04, 8'h12, 8'h15, 8'h01, 8'h06, 8'h25), 1'b1);
        check("err_flag/state", 32'(state), 32'd0);
        send("hour24", mk(8'h04, 8'h24, 8'h15, 8'h01, 8'h06, 8'h25), 1'b0);
        check("hour24/state", 32'(state), 32'd0);
        send("min60", mk(8'h60, 8'h12, 8'h15, 8'h01, 8'h06, 8'h25), 1'b0);
        check("min60/state", 32'(state), 32'd0);
        send("month13", mk(8'h04, 8'h12, 8'h15, 8'h01, 8'h13, 8'h25), 1'b0);
        check("month13/state", 32'(state), 32'd0);

        send("12:04", mk(8'h04, 8'h12, 8'h15, 8'h01, 8'h06, 8'h25), 1'b0);
        expect_out("12:04", 1, 0, 0, 0);
        send("12:05", mk(8'h05, 8'h12, 8'h15, 8'h01, 8'h06, 8'h25), 1'b0);
        expect_out("12:05", 2, 1, 1, 0);
        @(negedge clk);
        check("load_one_pulse", 32'(load), 32'd0);

        f_bad     = mk(8'h06, 8'h12, 8'h15, 8'h01, 8'h06, 8'h25);
        f_bad[28] = ~f_bad[28];
        send("bad_par", f_bad, 1'b0);
        expect_out("bad_par", 3, 0, 1, 1);
        send("12:06", mk(8'h06, 8'h12, 8'h15, 8'h01, 8'h06, 8'h25), 1'b0);
        expect_out("12:06_noref", 3, 0, 1, 2);
        send("12:07", mk(8'h07, 8'h12, 8'h15, 8'h01, 8'h06, 8'h25), 1'b0);
        expect_out("12:07", 2, 1, 1, 0);

        send("23:58", mk(8'h58, 8'h23, 8'h31, 8'h03, 8'h12, 8'h25), 1'b0);
        expect_out("23:58", 3, 0, 1, 1);
        send("23:59", mk(8'h59, 8'h23, 8'h31, 8'h03, 8'h12, 8'h25), 1'b0);
        expect_out("23:59", 2, 1, 1, 0);
        send("00:00", mk(8'h00, 8'h00, 8'h01, 8'h04, 8'h01, 8'h26), 1'b0);
        expect_out("rollover", 2, 1, 1, 0);

        // Frame lands on the same cycle as the terminal tick.
        @(negedge clk);
        clk_en = 1'b1;
        repeat (TO - 1) @(negedge clk);
        data        = mk(8'h01, 8'h00, 8'h01, 8'h04, 8'h01, 8'h26);
        frame_valid = 1'b1;
        @(negedge clk);
        frame_valid = 1'b0;
        $display("frame 00:01+tick: state=%0d load=%0d locked=%0d missed=%0d",
                 state, load, locked, missed);
        expect_out("coincide", 2, 1, 1, 0);

        repeat (TO - 1) @(negedge clk);
        check("pre_timeout/state", 32'(state), 32'd2);
        @(negedge clk);
        expect_out("timeout1", 3, 0, 1, 1);

        repeat (59 * TO) @(negedge clk);
        expect_out("miss60", 3, 0, 1, 60);
        repeat (TO) @(negedge clk);
        expect_out("miss61", 0, 0, 0, 61);
        clk_en = 1'b0;

        send("12:04b", mk(8'h04, 8'h12, 8'h15, 8'h01, 8'h06, 8'h25), 1'b0);
        check("12:04b/state", 32'(state), 32'd1);
        send("12:05b", mk(8'h05, 8'h12, 8'h15, 8'h01, 8'h06, 8'h25), 1'b0);
        expect_out("12:05b", 2, 1, 1, 0);

        @(negedge clk);
        data        = mk(8'h06, 8'h12, 8'h15, 8'h01, 8'h06, 8'h25);
        frame_valid = 1'b1;
        rst         = 1'b0;
        #1;
        expect_out("rst_async", 0, 0, 0, 0);
        @(negedge clk);
        frame_valid = 1'b0;
        check("rst_hold/load", 32'(load), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_rel1/load", 32'(load), 32'd0);
        check("rst_rel1/state", 32'(state), 32'd0);
        @(negedge clk);
        check("rst_rel2/load", 32'(load), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dcf77_sync_ctrl.md
DCF77_SYNC_CTRL -- requirements
Module: dcf77_sync_ctrl

Interface
REQ-001 SHALL have parameter N_CONFIRM, default 2: number of consecutive consistent frames needed to reach LOCKED (valid range 1..15).
REQ-002 SHALL have parameter HOLDOVER_MAX, default 60: missed or bad minutes tolerated in HOLDOVER before returning to HUNT (valid range 1..255).
REQ-003 SHALL have parameter TIMEOUT_TICKS, default 6100: number of clk_en ticks without frame_valid that counts as one missed minute.
REQ-004 Port clk, input, 1: system clock.
REQ-005 Port rst, input, 1: reset; one clock, reset asynchronous and active-low.
REQ-006 Port clk_en, input, 1: 10 ms tick, one clk wide.
REQ-007 Port frame_valid, input, 1: one-cycle pulse when the receiver completes a minute frame.
REQ-008 Port frame_error, input, 1: receiver error flag, sampled together with frame_valid.
REQ-009 Port data, input, 59: held frame bits [58:0], stable from frame_valid until the next frame_valid.
REQ-010 Port load, output, 1: one-cycle pulse; tells the clock to load the data fields.
REQ-011 Port locked, output, 1: high in LOCKED and HOLDOVER.
REQ-012 Port state, output, 2: current state encoding.
REQ-013 Port missed, output, 8: current holdover miss count.

Function
REQ-014 Frame SHALL be valid only when all of the following hold: frame_error=0; data[0]=0; data[20]=1; even parity data[28:21], data[35:29] and data[58:36].
REQ-015 Frame SHALL additionally require these field ranges, all BCD: minute<=59, hour<=23, day 1..31, month 1..12, dow 1..7, both year digits <=9.
REQ-016 A valid frame SHALL be consistent when a reference frame exists and minute = BCD(ref_minute+1).
REQ-017 For minute<>00, consistency SHALL also require hour/day/dow/month/year equal to the reference; for ref_minute=59 and minute=00, the other fields SHALL be unchecked.
REQ-018 Every valid frame SHALL become the new reference; an invalid frame SHALL clear the reference-present flag.
REQ-019 States SHALL be HUNT=0, VERIFY=1, LOCKED=2, HOLDOVER=3; reset state HUNT.
REQ-020 HUNT: valid frame -> VERIFY with confirm=1, or directly LOCKED if N_CONFIRM=1.
REQ-021 VERIFY: consistent frame -> confirm+1, reaching N_CONFIRM -> LOCKED; valid but inconsistent frame -> confirm=1, stay; invalid frame or timeout -> HUNT.
REQ-022 LOCKED: consistent frame -> stay; invalid, inconsistent or timeout -> HOLDOVER with missed=1.
REQ-023 HOLDOVER: consistent frame -> LOCKED with missed=0; otherwise missed+1 (saturating at 255), and missed>HOLDOVER_MAX -> HUNT.
REQ-024 load SHALL pulse the cycle after frame_valid for every consistent frame that enters or stays in LOCKED; no other cause SHALL produce load.
REQ-025 Timeout counter SHALL increment on clk_en and clear on frame_valid or on reaching TIMEOUT_TICKS (which also registers one timeout event).
REQ-026 When frame_valid and timeout coincide in one cycle, the frame SHALL take priority and the timeout SHALL be discarded.
REQ-027 All outputs SHALL be registered; state/locked/missed SHALL update the cycle after frame_valid or timeout.

Reset
REQ-028 rst low SHALL asynchronously force state=HUNT, load=0, locked=0, missed=0, confirm=0, timeout counter=0, and clear the reference flag.
REQ-029 Reset asserted mid-frame SHALL discard any pending load.

Structure
REQ-030 Package types SHALL hold the dcf77_state_t enum and the frame bit-position constants; bcd_t SHALL be reused from types.
REQ-031 Validity and range checking SHALL live in the combinational sub-module dcf77_frame_check.
REQ-032 Consistency check, FSM and counters SHALL reside in dcf77_sync_ctrl.

Verification
REQ-033 Bench SHALL cover: frames 12:04, 12:05 with N_CONFIRM=2 -> state HUNT->VERIFY->LOCKED, load one pulse after the second frame, locked=1.
REQ-034 Bench SHALL cover: while LOCKED, frame with bad data[28] parity -> HOLDOVER, missed=1, no load; next frame 12:07 following a valid 12:06 reference -> LOCKED, load, missed=0.
REQ-035 Bench SHALL cover: LOCKED, then no frame_valid for 61x6100 ticks with HOLDOVER_MAX=60 -> missed reaches 61, state HUNT, locked=0.
REQ-036 Bench SHALL cover: reference 23:59 on 31.12.25 followed by 00:00 on 01.01.26 -> consistent, load pulses.
REQ-037 Bench SHALL cover: frame_valid coinciding with the 6100th tick -> frame processed, missed unchanged.
REQ-038 Bench SHALL cover: rst low in LOCKED with frame_valid the same cycle -> state=HUNT and load=0 immediately, and no load after release.
